// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings,
// the reserved-mode test and the per-stage control payload.
package shifter_pkg;

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    // Control part of a stage payload; data and tag travel beside it because
    // their widths follow the module parameters.
    typedef struct packed {
        logic [2:0] mode;
        logic       ovf;
        logic       sign;
        logic       err;
    } stage_ctl_t;

    function automatic logic is_reserved(input logic [2:0] mode);
        return mode > MODE_SRA;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operation and result channels of the barrel shifter.
// A transfer happens on a rising edge where valid && ready are both high.
interface pipelined_barrel_shifter_if #(
    parameter int W     = 32,
    parameter int TAG_W = 4
);
    localparam int AW = $clog2(W) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [AW-1:0]    in_amt;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// One barrel level: moves data by 2^STAGE positions when amount bit STAGE
// is set, with fill chosen by the mode, then registers the payload.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4,
    parameter int STAGE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [$clog2(W):0]     in_amt,
    input  stage_ctl_t             in_ctl,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(W):0]     out_amt,
    output stage_ctl_t             out_ctl
);
    localparam int D = 1 << STAGE;

    logic [W-1:0] nxt_data;

    // SRA fills from the captured original sign, not the current MSB.
    always_comb begin
        nxt_data = in_data;
        if (in_amt[STAGE]) begin
            case (in_ctl.mode)
                MODE_ROL: nxt_data = {in_data[W-D-1:0], in_data[W-1:W-D]};
                MODE_ROR: nxt_data = {in_data[D-1:0], in_data[W-1:D]};
                MODE_SLL: nxt_data = {in_data[W-D-1:0], {D{1'b0}}};
                MODE_SRL: nxt_data = {{D{1'b0}}, in_data[W-1:D]};
                MODE_SRA: nxt_data = {{D{in_ctl.sign}}, in_data[W-1:D]};
                default:  nxt_data = in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_amt   <= '0;
            out_ctl   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= nxt_data;
            out_tag   <= in_tag;
            out_amt   <= in_amt;
            out_ctl   <= in_ctl;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit: log2(W) barrel stages plus an output register,
// all advanced by one global enable that drops while the result is stalled.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int S  = $clog2(W);
    localparam int AW = S + 1;

    logic             en;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;

    logic             valid_c [0:S];
    logic [W-1:0]     data_c  [0:S];
    logic [TAG_W-1:0] tag_c   [0:S];
    logic [AW-1:0]    amt_c   [0:S];
    stage_ctl_t       ctl_c   [0:S];
    stage_ctl_t       ctl_in;
    logic [W-1:0]     fin_data;

    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en;

    // Out-of-range amounts only matter for shifts; rotates wrap naturally
    // because the top amount bit never drives a barrel level.
    always_comb begin
        ctl_in      = '0;
        ctl_in.mode = bus.in_mode;
        ctl_in.err  = is_reserved(bus.in_mode);
        ctl_in.sign = bus.in_data[W-1];
        ctl_in.ovf  = bus.in_amt[S] &&
                      (bus.in_mode == MODE_SLL || bus.in_mode == MODE_SRL ||
                       bus.in_mode == MODE_SRA);
    end

    assign valid_c[0] = bus.in_valid;
    assign data_c[0]  = bus.in_data;
    assign tag_c[0]   = bus.in_tag;
    assign amt_c[0]   = bus.in_amt;
    assign ctl_c[0]   = ctl_in;

    for (genvar i = 0; i < S; i++) begin : g_stage
        shift_stage #(
            .W     (W),
            .TAG_W (TAG_W),
            .STAGE (i)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (valid_c[i]),
            .in_data   (data_c[i]),
            .in_tag    (tag_c[i]),
            .in_amt    (amt_c[i]),
            .in_ctl    (ctl_c[i]),
            .out_valid (valid_c[i+1]),
            .out_data  (data_c[i+1]),
            .out_tag   (tag_c[i+1]),
            .out_amt   (amt_c[i+1]),
            .out_ctl   (ctl_c[i+1])
        );
    end

    always_comb begin
        fin_data = data_c[S];
        if (ctl_c[S].ovf) begin
            fin_data = {W{ctl_c[S].mode == MODE_SRA && ctl_c[S].sign}};
        end
        if (!valid_c[S]) begin
            fin_data = '0;
        end
    end

    // Result fields are zeroed for bubbles so idle outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= valid_c[S];
            out_data_q  <= fin_data;
            out_tag_q   <= valid_c[S] ? tag_c[S] : '0;
            out_err_q   <= valid_c[S] && ctl_c[S].err;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors, random
// streams with and without output stalls, reserved modes and async reset.
module tb_pipelined_barrel_shifter;
    localparam int W     = 32;
    localparam int TAG_W = 4;
    localparam int AW    = $clog2(W) + 1;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   chk_lat = 1'b1;

    logic [W+TAG_W:0] exp_q[$];
    int               acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    pipelined_barrel_shifter_if #(.W(W), .TAG_W(TAG_W)) bus ();

    pipelined_barrel_shifter #(.W(W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result bit positions computed directly from the shift rules.
    function automatic logic [W:0] ref_model(input logic [W-1:0] d, input logic [AW-1:0] amt,
                                             input logic [2:0] mode);
        logic [W-1:0] res;
        int k;
        int r;
        k = int'(amt);
        r = k % W;
        res = '0;
        case (mode)
            3'd0: for (int i = 0; i < W; i++) res[(i + r) % W] = d[i];
            3'd1: for (int i = 0; i < W; i++) res[i] = d[(i + r) % W];
            3'd2: res = (k >= W) ? '0 : d << k;
            3'd3: res = (k >= W) ? '0 : d >> k;
            3'd4: res = (k >= W) ? {W{d[W-1]}} : W'($signed(d) >>> k);
            default: return {1'b1, d};
        endcase
        return {1'b0, res};
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] amt, input logic [2:0] mode,
                        input logic [TAG_W-1:0] tag, input logic [W-1:0] exp_d,
                        input logic exp_e, input bit push);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = amt;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok && push) begin
                exp_q.push_back({exp_e, tag, exp_d});
                acc_q.push_back(cycle + 1);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted tag=%0h", tag);
        end
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag);
        logic [W-1:0]  d;
        logic [AW-1:0] amt;
        logic [2:0]    mode;
        logic [W:0]    r;
        d    = $urandom;
        amt  = AW'($urandom_range(0, 2 * W - 1));
        mode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        r    = ref_model(d, amt, mode);
        send(d, amt, mode, tag, r[W-1:0], r[W], 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: handshake rule, stall stability, idle zeros and scoreboard pops.
    logic                 prev_stall = 1'b0;
    logic [W+TAG_W+1:0]   prev_out = '0;
    always @(negedge clk) begin
        logic [W+TAG_W:0] e;
        int a;
        if (rst_n) begin
            check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (prev_stall)
                check("stall_hold", 64'({bus.out_valid, bus.out_err, bus.out_tag, bus.out_data}),
                      64'(prev_out));
            if (!bus.out_valid)
                check("idle_zero", 64'({bus.out_err, bus.out_tag, bus.out_data}), 64'(0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h tag=%h required=none",
                             bus.out_data, bus.out_tag);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e[W-1:0]));
                    check("out_tag", 64'(bus.out_tag), 64'(e[W+TAG_W-1:W]));
                    check("out_err", 64'(bus.out_err), 64'(e[W+TAG_W]));
                    if (chk_lat) check("latency", 64'(cycle - a), 64'(LAT));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.out_err, bus.out_tag, bus.out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_fields", 64'({bus.out_err, bus.out_tag, bus.out_data}), 64'(0));
        rst_n = 1'b1;

        // Rotates, including an amount above W that must wrap.
        send(32'h8000_0001, 6'd1,  3'b000, 4'd1, 32'h0000_0003, 1'b0, 1'b1);
        send(32'h0000_0001, 6'd4,  3'b001, 4'd2, 32'h1000_0000, 1'b0, 1'b1);
        send(32'h1234_5678, 6'd36, 3'b001, 4'd3, 32'h8123_4567, 1'b0, 1'b1);
        drain();

        // Shifts and range boundaries.
        send(32'h0000_FFFF, 6'd16, 3'b010, 4'd4, 32'hFFFF_0000, 1'b0, 1'b1);
        send(32'hF000_0000, 6'd28, 3'b011, 4'd5, 32'h0000_000F, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 6'd32, 3'b010, 4'd6, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 6'd31, 3'b100, 4'd7, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h4000_0000, 6'd40, 3'b100, 4'd8, 32'h0000_0000, 1'b0, 1'b1);
        send(32'hA5A5_A5A5, 6'd0,  3'b100, 4'd9, 32'hA5A5_A5A5, 1'b0, 1'b1);
        send(32'hC000_0000, 6'd63, 3'b100, 4'hA, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Reserved mode passes data with err, next defined mode clears err.
        send(32'hDEAD_BEEF, 6'd7, 3'b101, 4'hB, 32'hDEAD_BEEF, 1'b1, 1'b1);
        send(32'h8000_0000, 6'd4, 3'b011, 4'hC, 32'h0800_0000, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) send_rand(TAG_W'(i));
        drain();

        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_rand(TAG_W'(i));
            end
            begin
                repeat (8) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // Async reset with three operations in flight; none may emerge.
        send(32'h1111_1111, 6'd1, 3'b000, 4'hD, 32'h0, 1'b0, 1'b0);
        send(32'h2222_2222, 6'd2, 3'b001, 4'hE, 32'h0, 1'b0, 1'b0);
        send(32'h3333_3333, 6'd3, 3'b010, 4'hF, 32'h0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("async_rst_out_data", 64'(bus.out_data), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h0000_0001, 6'd31, 3'b000, 4'h1, 32'h8000_0000, 1'b0, 1'b1);
        drain();
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter and rotator with valid/ready handshakes on input and output. Supports rotate left/right, logical left/right and arithmetic right shift. Has one register level per log2 shift stage, so it accepts one operation per cycle. Sits in the datapath between operand staging and ALU writeback; it is the pipelined, multi-mode successor to the combinational rotate-only shifter.

Parameters:
W, 32, data width; must be a power of two, at least 4
TAG_W, 4, sideband tag width; the tag is carried alongside the data unchanged, for ordering checks

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operation valid
in_ready  output  1  block can accept an input this cycle
in_data  input  W  operand
in_amt  input  $clog2(W)+1  shift amount, 0..2W-1
in_mode  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 reserved
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  W  result
out_tag  output  TAG_W  tag of the operation that produced out_data
out_err  output  1  1 when the operation used a reserved mode

Behaviour:
- Handshakes
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline
  - S = $clog2(W) register stages; stage i applies a conditional move of 2^i positions, selected by in_amt[i].
  - Each stage holds: valid, data, mode, amount-overflow flag, sign bit, tag, err.
  - Latency: an operation accepted at edge t appears on out_valid/out_data after edge t+S (5 for W=32), provided there is no stall.
- Stall
  - stall = out_valid && !out_ready.
  - On stall, all stages hold their contents.
  - in_ready = !stall, combinational.
  - Bubbles are not compressed; a simple global enable is used.
  - Throughput is 1 operation per cycle when out_ready=1.
- Arithmetic, with k = in_amt
  - Rotates use k mod W; bit $clog2(W) of in_amt is ignored.
  - ROL result is bit-identical to ROR by (W - k) mod W.
  - SLL/SRL with k >= W give all zeros.
  - SRA with k >= W gives W copies of in_data[W-1].
  - SRA fill bits always equal the original in_data[W-1].
  - k = 0 returns in_data unchanged for every valid mode.
- Reserved modes (101-111)
  - out_data = in_data unchanged and out_err = 1.
  - The operation still flows through the pipeline with normal latency.
  - out_err = 0 for all defined modes.
- Ordering: results leave in acceptance order; out_tag equals the in_tag captured with the same operation.
- Reset (asynchronous, any time)
  - All stage valid bits go to 0 immediately; out_valid=0, out_data=0, out_tag=0, out_err=0.
  - in_ready goes to 1 (no stall possible while empty).
  - In-flight operations are discarded with no partial output.
  - The first input is accepted on the first rising edge after rst_n deasserts.
- Invalid stages: data registers may hold stale values, but out_data must read 0 whenever out_valid=0.
- Simultaneous events
  - Accept and emit in the same cycle is legal when out_ready=1.
  - in_valid while stalled is not accepted; the source must hold its inputs.
  - out_data/out_tag/out_err stay stable while out_valid && !out_ready.

Decomposition:
- Package shifter_pkg holds:
  - Mode localparams MODE_ROL=3'b000, MODE_ROR=3'b001, MODE_SLL=3'b010, MODE_SRL=3'b011, MODE_SRA=3'b100.
  - A function is_reserved(mode).
  - A stage-payload struct typedef (data, mode, ovf, sign, tag, err).
- Sub-module shift_stage, parameters W, TAG_W and STAGE:
  - One mux level of fixed distance 2^STAGE.
  - Handles rotate/shift fill per mode.
  - Contains a registered payload with an enable.
  - The top level instantiates it S times in a generate loop.

Test Plan:
- W=32, ROL 0x80000001 by 1 -> 0x00000003; ROR 0x00000001 by 4 -> 0x10000000; ROR 0x12345678 by 36 -> 0x81234567. Each out_valid exactly 5 cycles after acceptance, out_err=0.
- SLL 0x0000FFFF by 16 -> 0xFFFF0000; SRL 0xF0000000 by 28 -> 0x0000000F; SLL 0xFFFFFFFF by 32 -> 0x00000000; SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRA 0x40000000 by 40 -> 0x00000000.
- Back-to-back stream of 20 random operations with tags 0..15 wrapping, out_ready=1 -> one result per cycle after a 5-cycle fill, tags in order, all values match the reference model.
- Same stream with out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready, outputs stable during the stall, no loss or duplication.
- Mode 3'b101, in_data 0xDEADBEEF, amt 7 -> out_data 0xDEADBEEF, out_err=1 after 5 cycles; the next operation with mode SRL has out_err=0.
- Assert rst_n=0 with 3 operations in flight -> out_valid=0 and in_ready=1 asynchronously; after release, none of the 3 results ever appears, and a new ROL 0x1 by 31 -> 0x80000000 after 5 cycles.
